// File: rtl/riscv_mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module riscv_mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_be,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int            SW       = $clog2(STARVE_MAX + 1);
  localparam logic [3:0]    LAT_V    = 4'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_V = SW'(STARVE_MAX);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [3:0]    cnt_r, cnt_s;
  logic [SW-1:0] starve_r, starve_s;
  logic          owner_d_r, owner_d_s;
  logic          we_r, we_s;
  logic          rsp_cycle_s, accept_ok_s, grant_d_s, acc_d_s, acc_if_s;
  logic          unused_s;

  // Word alignment of fetch addresses drops the low address bits.
  assign unused_s = ^if_req_addr[1:0];

  // Arbitration: accept window and winner selection.
  always_comb begin
    rsp_cycle_s = (state_r == WAIT) && (cnt_r == LAT_V);
    // Holding off under rst keeps readys and mem_en low during reset.
    accept_ok_s = !rst && ((state_r == IDLE) || rsp_cycle_s);
    grant_d_s   = d_req_valid && !((starve_r == STARVE_V) && if_req_valid);
    acc_d_s     = accept_ok_s && grant_d_s;
    acc_if_s    = accept_ok_s && if_req_valid && !grant_d_s;
  end

  // Handshake, memory strobe and response outputs.
  always_comb begin
    if_req_ready = acc_if_s;
    d_req_ready  = acc_d_s;
    mem_en       = acc_d_s || acc_if_s;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_addr     = 32'h0000_0000;
    mem_wdata    = 32'h0000_0000;
    if (acc_d_s) begin
      mem_we    = d_req_we;
      mem_be    = d_req_we ? d_req_be : 4'hF;
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
    end else if (acc_if_s) begin
      mem_be   = 4'hF;
      mem_addr = {if_req_addr[31:2], 2'b00};
    end else begin
      mem_we = 1'b0;
    end
    if_rsp_valid = rsp_cycle_s && !owner_d_r;
    d_rsp_valid  = rsp_cycle_s && owner_d_r;
    if_rsp_data  = if_rsp_valid ? mem_rdata : 32'h0000_0000;
    d_rsp_rdata  = (d_rsp_valid && !we_r) ? mem_rdata : 32'h0000_0000;
  end

  // Next-state, latency counter, owner latch and starvation counter.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    owner_d_s = owner_d_r;
    we_s      = we_r;
    starve_s  = starve_r;
    case (state_r)
      IDLE: begin
        if (acc_d_s || acc_if_s) begin
          state_s   = WAIT;
          cnt_s     = 4'd1;
          owner_d_s = acc_d_s;
          we_s      = acc_d_s ? d_req_we : 1'b0;
        end else begin
          cnt_s = 4'd0;
        end
      end
      WAIT: begin
        if (rsp_cycle_s) begin
          if (acc_d_s || acc_if_s) begin
            cnt_s     = 4'd1;
            owner_d_s = acc_d_s;
            we_s      = acc_d_s ? d_req_we : 1'b0;
          end else begin
            state_s = IDLE;
            cnt_s   = 4'd0;
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
    if (acc_d_s) begin
      if (if_req_valid) begin
        starve_s = (starve_r == STARVE_V) ? STARVE_V : starve_r + SW'(1);
      end else begin
        starve_s = '0;
      end
    end else if (acc_if_s) begin
      starve_s = '0;
    end else begin
      starve_s = starve_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      starve_r  <= '0;
      owner_d_r <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      starve_r  <= starve_s;
      owner_d_r <= owner_d_s;
      we_r      <= we_s;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench: one MEM_LAT=1 and one MEM_LAT=3 arbiter share stimulus; each section
// resets both and checks the instance it targets.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, d_req_valid, d_req_we;
  logic [31:0] if_req_addr, d_req_addr, d_req_wdata, mem_rdata;
  logic [3:0]  d_req_be;

  logic        a_if_rdy, a_if_rv, a_d_rdy, a_d_rv, a_en, a_we;
  logic [31:0] a_if_rd, a_d_rd, a_addr, a_wd;
  logic [3:0]  a_be;
  logic        b_if_rdy, b_if_rv, b_d_rdy, b_d_rv, b_en, b_we;
  logic [31:0] b_if_rd, b_d_rd, b_addr, b_wd;
  logic [3:0]  b_be;

  int total = 0;
  int bad   = 0;

  riscv_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_l1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(a_if_rdy), .if_req_addr(if_req_addr),
    .if_rsp_valid(a_if_rv), .if_rsp_data(a_if_rd),
    .d_req_valid(d_req_valid), .d_req_ready(a_d_rdy), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(a_d_rv), .d_rsp_rdata(a_d_rd),
    .mem_en(a_en), .mem_we(a_we), .mem_be(a_be), .mem_addr(a_addr),
    .mem_wdata(a_wd), .mem_rdata(mem_rdata)
  );

  riscv_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_l3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(b_if_rdy), .if_req_addr(if_req_addr),
    .if_rsp_valid(b_if_rv), .if_rsp_data(b_if_rd),
    .d_req_valid(d_req_valid), .d_req_ready(b_d_rdy), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(b_d_rv), .d_rsp_rdata(b_d_rd),
    .mem_en(b_en), .mem_we(b_we), .mem_be(b_be), .mem_addr(b_addr),
    .mem_wdata(b_wd), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [9:0] seq;
  int         n;

  initial begin
    rst          = 1'b1;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    if_req_addr  = 32'h0;
    d_req_addr   = 32'h0;
    d_req_wdata  = 32'h0;
    d_req_be     = 4'h0;
    mem_rdata    = 32'h0;

    // Reset: everything low even with both requesters valid.
    @(negedge clk);
    chk("rst_if_ready", {31'd0, a_if_rdy}, 32'd0);
    chk("rst_d_ready",  {31'd0, b_d_rdy},  32'd0);
    chk("rst_mem_en",   {31'd0, a_en | b_en}, 32'd0);
    chk("rst_rsp",      {30'd0, a_if_rv, b_d_rv}, 32'd0);

    // MEM_LAT=1 fetch stream 0x0, 0x4, 0x8.
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("f0_ready", {31'd0, a_if_rdy}, 32'd1);
    chk("f0_en",    {31'd0, a_en}, 32'd1);
    chk("f0_addr",  a_addr, 32'h0);
    chk("f0_rsp",   {31'd0, a_if_rv}, 32'd0);
    tick();
    if_req_addr = 32'h4; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("f1_en",   {31'd0, a_en}, 32'd1);
    chk("f1_addr", a_addr, 32'h4);
    chk("f1_rsp",  {31'd0, a_if_rv}, 32'd1);
    chk("f1_data", a_if_rd, 32'h1111_1111);
    tick();
    if_req_addr = 32'h8; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("f2_en",   {31'd0, a_en}, 32'd1);
    chk("f2_addr", a_addr, 32'h8);
    chk("f2_data", a_if_rd, 32'h2222_2222);
    tick();
    if_req_valid = 1'b0; mem_rdata = 32'h3333_3333;
    @(negedge clk);
    chk("f3_rsp",  {31'd0, a_if_rv}, 32'd1);
    chk("f3_data", a_if_rd, 32'h3333_3333);
    chk("f3_en",   {31'd0, a_en}, 32'd0);
    tick();
    @(negedge clk);
    chk("f4_rsp", {31'd0, a_if_rv}, 32'd0);

    // MEM_LAT=3, both valid: data first, fetch accepted on data's response cycle.
    do_reset();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h200;
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    @(negedge clk);
    chk("p0_d_ready",  {31'd0, b_d_rdy}, 32'd1);
    chk("p0_if_ready", {31'd0, b_if_rdy}, 32'd0);
    chk("p0_addr",     b_addr, 32'h200);
    chk("p0_be",       {28'd0, b_be}, 32'hF);
    tick();
    d_req_valid = 1'b0;
    @(negedge clk);
    chk("p1_en",       {31'd0, b_en}, 32'd0);
    chk("p1_if_ready", {31'd0, b_if_rdy}, 32'd0);
    tick();
    @(negedge clk);
    chk("p2_en", {31'd0, b_en}, 32'd0);
    tick();
    mem_rdata = 32'h55AA_1234;
    @(negedge clk);
    chk("p3_d_rsp",    {31'd0, b_d_rv}, 32'd1);
    chk("p3_d_data",   b_d_rd, 32'h55AA_1234);
    chk("p3_if_ready", {31'd0, b_if_rdy}, 32'd1);
    chk("p3_addr",     b_addr, 32'h40);
    tick();
    if_req_valid = 1'b0;
    tick();
    tick();
    mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("p6_if_rsp",  {31'd0, b_if_rv}, 32'd1);
    chk("p6_if_data", b_if_rd, 32'h0BAD_F00D);
    chk("p6_d_rsp",   {31'd0, b_d_rv}, 32'd0);
    tick();

    // MEM_LAT=3, reset while WAIT cnt=2 drops the response.
    d_req_valid = 1'b1; d_req_addr = 32'h300;
    @(negedge clk);
    chk("r0_d_ready", {31'd0, b_d_rdy}, 32'd1);
    tick();
    d_req_valid = 1'b0;
    tick();
    rst = 1'b1; d_req_valid = 1'b1; if_req_valid = 1'b1;
    @(negedge clk);
    chk("r2_en",    {31'd0, b_en}, 32'd0);
    chk("r2_ready", {30'd0, b_d_rdy, b_if_rdy}, 32'd0);
    chk("r2_rsp",   {30'd0, b_d_rv, b_if_rv}, 32'd0);
    tick();
    @(negedge clk);
    chk("r3_rsp", {30'd0, b_d_rv, b_if_rv}, 32'd0);
    tick();
    rst = 1'b0; if_req_valid = 1'b0; d_req_addr = 32'h304;
    @(negedge clk);
    chk("r4_d_ready", {31'd0, b_d_rdy}, 32'd1);
    chk("r4_addr",    b_addr, 32'h304);
    chk("r4_rsp",     {31'd0, b_d_rv}, 32'd0);
    tick();

    // MEM_LAT=3, both valid continuously: D,D,D,D,IF,D,D,D,D,IF.
    do_reset();
    d_req_valid = 1'b1; if_req_valid = 1'b1;
    seq = 10'd0; n = 0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (b_d_rdy) begin
        seq[n] = 1'b1; n++;
      end else if (b_if_rdy) begin
        seq[n] = 1'b0; n++;
      end
      tick();
    end
    chk("starve_count", n, 32'd10);
    chk("starve_order", {22'd0, seq}, {22'd0, 10'b01111_01111});

    // MEM_LAT=1 store: byte enables passed, completion returns zero data.
    do_reset();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h100;
    d_req_be = 4'b0011; d_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_en",    {31'd0, a_en}, 32'd1);
    chk("st_we",    {31'd0, a_we}, 32'd1);
    chk("st_be",    {28'd0, a_be}, 32'h3);
    chk("st_addr",  a_addr, 32'h100);
    chk("st_wdata", a_wd, 32'hDEAD_BEEF);
    tick();
    d_req_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("st_rsp",   {31'd0, a_d_rv}, 32'd1);
    chk("st_rdata", a_d_rd, 32'h0);
    tick();

    // MEM_LAT=1 unaligned fetch address gets word-aligned.
    d_req_we = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h7;
    @(negedge clk);
    chk("fa_en",   {31'd0, a_en}, 32'd1);
    chk("fa_addr", a_addr, 32'h4);
    chk("fa_be",   {28'd0, a_be}, 32'hF);
    chk("fa_we",   {31'd0, a_we}, 32'd0);
    tick();
    if_req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
